// File: rtl/fixed_lpc_encoder_if.sv
// Sample-in / residual-out bundle for fixed_lpc_encoder (master = sample source, slave = encoder).
// oAbsSum/oSumValid exist only when FIXED_LPC_ABSSUM_EN is defined.
interface fixed_lpc_encoder_if #(
  parameter int SAMPLE_W = 16,
  parameter int RESID_W  = SAMPLE_W + 4,
  parameter int SUM_W    = 32
);
  logic                       iEnable;
  logic                       iValid;
  logic                       iStart;
  logic                       iLast;
  logic [2:0]                 iOrder;
  logic signed [SAMPLE_W-1:0] iSample;
  logic                       oValid;
  logic                       oWarmup;
  logic                       oLast;
  logic signed [RESID_W-1:0]  oResidual;

  if (SUM_W < RESID_W) begin : g_bad_sum_w
    $error("SUM_W must not be narrower than RESID_W");
  end

`ifdef FIXED_LPC_ABSSUM_EN
  logic [SUM_W-1:0]           oAbsSum;
  logic                       oSumValid;

  modport master (
    output iEnable, iValid, iStart, iLast, iOrder, iSample,
    input  oValid, oWarmup, oLast, oResidual, oAbsSum, oSumValid
  );
  modport slave (
    input  iEnable, iValid, iStart, iLast, iOrder, iSample,
    output oValid, oWarmup, oLast, oResidual, oAbsSum, oSumValid
  );
`else
  modport master (
    output iEnable, iValid, iStart, iLast, iOrder, iSample,
    input  oValid, oWarmup, oLast, oResidual
  );
  modport slave (
    input  iEnable, iValid, iStart, iLast, iOrder, iSample,
    output oValid, oWarmup, oLast, oResidual
  );
`endif
endinterface

// File: rtl/fixed_lpc_encoder.sv
// FLAC fixed-predictor residual encoder, orders 0..4, 3-stage pipeline with global stall.
// Optional block |residual| accumulator enabled by FIXED_LPC_ABSSUM_EN.
module fixed_lpc_encoder #(
  parameter int SAMPLE_W = 16,
  parameter int RESID_W  = SAMPLE_W + 4,
  parameter int SUM_W    = 32
) (
  input logic                iClock,
  input logic                iReset,
  fixed_lpc_encoder_if.slave bus
);

  if (SAMPLE_W < 8 || SAMPLE_W > 24) begin : g_bad_sample_w
    $error("SAMPLE_W must be within 8..24");
  end
  if (RESID_W < SAMPLE_W + 4) begin : g_bad_resid_w
    $error("RESID_W too narrow for the order-4 worst case");
  end
  if (SUM_W < RESID_W) begin : g_bad_sum_w
    $error("SUM_W must not be narrower than RESID_W");
  end

  logic                       accept;
  logic [2:0]                 order_q, order_d;
  logic [2:0]                 warm_cnt_q, warm_cnt_d;
  logic signed [SAMPLE_W-1:0] hist_q [4];
  logic signed [SAMPLE_W-1:0] hist_d [4];

  logic [2:0]                 order_eff;
  logic [2:0]                 warm_cnt_eff;
  logic signed [SAMPLE_W-1:0] hist_eff [4];

  logic                       s0_valid_q, s0_valid_d;
  logic                       s0_warm_q, s0_warm_d;
  logic                       s0_last_q, s0_last_d;
  logic [2:0]                 s0_order_q, s0_order_d;
  logic signed [SAMPLE_W-1:0] s0_x_q, s0_x_d;
  logic signed [SAMPLE_W-1:0] s0_h_q [4];
  logic signed [SAMPLE_W-1:0] s0_h_d [4];

  logic signed [RESID_W-1:0]  xe;
  logic signed [RESID_W-1:0]  he [4];
  logic                       s1_valid_q, s1_valid_d;
  logic                       s1_warm_q, s1_warm_d;
  logic                       s1_last_q, s1_last_d;
  logic signed [RESID_W-1:0]  s1_pa_q, s1_pa_d;
  logic signed [RESID_W-1:0]  s1_pb_q, s1_pb_d;

  logic                       out_valid_q, out_valid_d;
  logic                       out_warm_q, out_warm_d;
  logic                       out_last_q, out_last_d;
  logic signed [RESID_W-1:0]  out_res_q, out_res_d;

  assign accept = bus.iEnable & bus.iValid;

  // A start sample sees a fresh block: new order, empty history, zero warm-up count.
  always_comb begin
    order_eff    = order_q;
    warm_cnt_eff = warm_cnt_q;
    hist_eff     = hist_q;
    if (bus.iStart) begin
      order_eff    = (bus.iOrder > 3'd4) ? 3'd4 : bus.iOrder;
      warm_cnt_eff = 3'd0;
      for (int k = 0; k < 4; k++) hist_eff[k] = '0;
    end
  end

  always_comb begin
    order_d    = order_q;
    warm_cnt_d = warm_cnt_q;
    hist_d     = hist_q;
    s0_valid_d = accept;
    s0_warm_d  = 1'b0;
    s0_last_d  = 1'b0;
    s0_order_d = s0_order_q;
    s0_x_d     = s0_x_q;
    s0_h_d     = s0_h_q;
    if (accept) begin
      order_d    = order_eff;
      warm_cnt_d = (warm_cnt_eff < order_eff) ? warm_cnt_eff + 3'd1 : warm_cnt_eff;
      hist_d[0]  = bus.iSample;
      hist_d[1]  = hist_eff[0];
      hist_d[2]  = hist_eff[1];
      hist_d[3]  = hist_eff[2];
      s0_warm_d  = (warm_cnt_eff < order_eff);
      s0_last_d  = bus.iLast;
      s0_order_d = order_eff;
      s0_x_d     = bus.iSample;
      s0_h_d     = hist_eff;
    end
  end

  // Split the predictor into two partial sums so the final adder stage stays short.
  always_comb begin
    xe = RESID_W'(s0_x_q);
    for (int k = 0; k < 4; k++) he[k] = RESID_W'(s0_h_q[k]);
    s1_pa_d = xe;
    s1_pb_d = '0;
    if (!s0_warm_q) begin
      case (s0_order_q)
        3'd1: s1_pa_d = xe - he[0];
        3'd2: begin
          s1_pa_d = xe - (he[0] <<< 1);
          s1_pb_d = he[1];
        end
        3'd3: begin
          s1_pa_d = xe - ((he[0] <<< 1) + he[0]);
          s1_pb_d = ((he[1] <<< 1) + he[1]) - he[2];
        end
        3'd4: begin
          s1_pa_d = xe - (he[0] <<< 2);
          s1_pb_d = ((he[1] <<< 2) + (he[1] <<< 1)) - (he[2] <<< 2) + he[3];
        end
        default: ;
      endcase
    end
    s1_valid_d = s0_valid_q;
    s1_warm_d  = s0_valid_q & s0_warm_q;
    s1_last_d  = s0_valid_q & s0_last_q;
  end

  always_comb begin
    out_valid_d = s1_valid_q;
    out_warm_d  = s1_valid_q & s1_warm_q;
    out_last_d  = s1_valid_q & s1_last_q;
    out_res_d   = s1_valid_q ? (s1_pa_q + s1_pb_q) : '0;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      order_q     <= '0;
      warm_cnt_q  <= '0;
      s0_valid_q  <= 1'b0;
      s0_warm_q   <= 1'b0;
      s0_last_q   <= 1'b0;
      s0_order_q  <= '0;
      s0_x_q      <= '0;
      for (int k = 0; k < 4; k++) begin
        hist_q[k] <= '0;
        s0_h_q[k] <= '0;
      end
      s1_valid_q  <= 1'b0;
      s1_warm_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_pa_q     <= '0;
      s1_pb_q     <= '0;
      out_valid_q <= 1'b0;
      out_warm_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_res_q   <= '0;
    end else if (bus.iEnable) begin
      order_q     <= order_d;
      warm_cnt_q  <= warm_cnt_d;
      s0_valid_q  <= s0_valid_d;
      s0_warm_q   <= s0_warm_d;
      s0_last_q   <= s0_last_d;
      s0_order_q  <= s0_order_d;
      s0_x_q      <= s0_x_d;
      for (int k = 0; k < 4; k++) begin
        hist_q[k] <= hist_d[k];
        s0_h_q[k] <= s0_h_d[k];
      end
      s1_valid_q  <= s1_valid_d;
      s1_warm_q   <= s1_warm_d;
      s1_last_q   <= s1_last_d;
      s1_pa_q     <= s1_pa_d;
      s1_pb_q     <= s1_pb_d;
      out_valid_q <= out_valid_d;
      out_warm_q  <= out_warm_d;
      out_last_q  <= out_last_d;
      out_res_q   <= out_res_d;
    end
  end

  assign bus.oValid    = out_valid_q;
  assign bus.oWarmup   = out_warm_q;
  assign bus.oLast     = out_last_q;
  assign bus.oResidual = out_res_q;

`ifdef FIXED_LPC_ABSSUM_EN
  logic                 s0_start_q, s1_start_q, out_start_q;
  logic [RESID_W-1:0]   abs_res;
  logic [SUM_W-1:0]     acc_base;
  logic [SUM_W:0]       acc_add;
  logic [SUM_W:0]       sum_ext;
  logic [SUM_W-1:0]     total;
  logic [SUM_W-1:0]     acc_q, acc_d;
  logic [SUM_W-1:0]     abs_sum_q, abs_sum_d;
  logic                 sum_valid_q, sum_valid_d;

  // The start flag rides with its sample so a mid-block restart drops the old total silently.
  always_comb begin
    abs_res     = out_res_q[RESID_W-1] ? -out_res_q : out_res_q;
    acc_base    = out_start_q ? '0 : acc_q;
    acc_add     = out_warm_q ? '0 : (SUM_W+1)'(abs_res);
    sum_ext     = {1'b0, acc_base} + acc_add;
    total       = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    acc_d       = acc_q;
    abs_sum_d   = abs_sum_q;
    sum_valid_d = 1'b0;
    if (out_valid_q) begin
      if (out_last_q) begin
        abs_sum_d   = total;
        sum_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d       = total;
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      s0_start_q  <= 1'b0;
      s1_start_q  <= 1'b0;
      out_start_q <= 1'b0;
      acc_q       <= '0;
      abs_sum_q   <= '0;
      sum_valid_q <= 1'b0;
    end else if (bus.iEnable) begin
      s0_start_q  <= accept & bus.iStart;
      s1_start_q  <= s0_valid_q & s0_start_q;
      out_start_q <= s1_valid_q & s1_start_q;
      acc_q       <= acc_d;
      abs_sum_q   <= abs_sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign bus.oAbsSum   = abs_sum_q;
  assign bus.oSumValid = sum_valid_q;
`endif

endmodule

// File: tb/tb_fixed_lpc_encoder.sv
// Scoreboard bench for fixed_lpc_encoder: directed blocks push expected outputs, monitors pop/compare.
`timescale 1ns/1ps
module tb_fixed_lpc_encoder;
  localparam int SW   = 16;
  localparam int RW   = SW + 4;
  localparam int SUMW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fixed_lpc_encoder_if #(.SAMPLE_W(SW), .RESID_W(RW), .SUM_W(SUMW)) bus ();
  fixed_lpc_encoder #(.SAMPLE_W(SW), .RESID_W(RW), .SUM_W(SUMW)) dut (
    .iClock (clk),
    .iReset (rst),
    .bus    (bus)
  );

  typedef struct {
    int res;
    bit warm;
    bit last;
    int stamp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   en_edges = 0;
  bit   mon_en;

`ifdef FIXED_LPC_ABSSUM_EN
  int     sum_q[$];
  longint macc = 0;
  bit     sum_en;
  int     sum_e;
`endif

  // Residual monitor: one pop per enabled edge that presents oValid; stamp checks 3-cycle latency.
  always @(posedge clk) begin
    mon_en = bus.iEnable && !rst;
    if (mon_en) en_edges++;
    #1;
    if (mon_en && bus.oValid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_out got res=%0d warm=%0b last=%0b, want no output",
                 int'(bus.oResidual), bus.oWarmup, bus.oLast);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(bus.oResidual) !== mon_e.res || bus.oWarmup !== mon_e.warm ||
            bus.oLast !== mon_e.last || en_edges != mon_e.stamp) begin
          failures++;
          $display("FAIL out got res=%0d warm=%0b last=%0b cyc=%0d want res=%0d warm=%0b last=%0b cyc=%0d",
                   int'(bus.oResidual), bus.oWarmup, bus.oLast, en_edges,
                   mon_e.res, mon_e.warm, mon_e.last, mon_e.stamp);
        end
      end
    end
  end

`ifdef FIXED_LPC_ABSSUM_EN
  always @(posedge clk) begin
    sum_en = bus.iEnable && !rst;
    #1;
    if (sum_en && bus.oSumValid) begin
      checks++;
      if (sum_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_sum got abssum=%0d, want no pulse", bus.oAbsSum);
      end else begin
        sum_e = sum_q.pop_front();
        if (bus.oAbsSum !== 32'(sum_e)) begin
          failures++;
          $display("FAIL abssum got %0d want %0d", bus.oAbsSum, sum_e);
        end
      end
    end
  end
`endif

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic push_exp(input int res, input bit wm, input bit ls, input bit st);
    exp_t e;
    e.res   = res;
    e.warm  = wm;
    e.last  = ls;
    e.stamp = en_edges + 3;
    exp_q.push_back(e);
`ifdef FIXED_LPC_ABSSUM_EN
    if (st) macc = 0;
    if (!wm) macc += (res < 0) ? -res : res;
    if (ls) begin
      sum_q.push_back(int'(macc));
      macc = 0;
    end
`else
    if (st && ls && wm && res == 0) e.stamp = e.stamp;
`endif
  endtask

  // x, start, last, order, expected residual, expected warm-up
  task automatic send(input int x, input bit st, input bit ls, input int ord,
                      input int res, input bit wm);
    @(negedge clk);
    bus.iEnable = 1'b1;
    bus.iValid  = 1'b1;
    bus.iStart  = st;
    bus.iLast   = ls;
    bus.iOrder  = 3'(ord);
    bus.iSample = 16'(x);
    push_exp(res, wm, ls, st);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.iEnable = 1'b1;
      bus.iValid  = 1'b0;
      bus.iStart  = 1'b0;
      bus.iLast   = 1'b0;
      bus.iSample = 16'($urandom);
    end
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.iEnable = 1'b0;
      bus.iValid  = 1'b1;
      bus.iStart  = 1'b1;
      bus.iLast   = 1'b1;
      bus.iOrder  = 3'd4;
      bus.iSample = 16'($urandom);
    end
  endtask

  initial begin
    bus.iEnable = 1'b1;
    bus.iValid  = 1'b0;
    bus.iStart  = 1'b0;
    bus.iLast   = 1'b0;
    bus.iOrder  = 3'd0;
    bus.iSample = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid",  int'(bus.oValid),    0);
    chk("rst_warmup", int'(bus.oWarmup),   0);
    chk("rst_last",   int'(bus.oLast),     0);
    chk("rst_resid",  int'(bus.oResidual), 0);
    rst = 1'b0;
    idle(2);

    // order 4 basic
    send(1, 1, 0, 4, 1, 1);
    send(2, 0, 0, 0, 2, 1);
    send(3, 0, 0, 0, 3, 1);
    send(4, 0, 0, 0, 4, 1);
    send(5, 0, 0, 0, 0, 0);
    send(7, 0, 1, 0, 1, 0);
    idle(6);

    // order 2 ramp with bubbles
    send(10, 1, 0, 2, 10, 1); idle(2);
    send(20, 0, 0, 0, 20, 1); idle(2);
    send(30, 0, 0, 0, 0, 0);  idle(2);
    send(40, 0, 1, 0, 0, 0);
    idle(6);

    // order 4 extremes, both signs
    send(32767,  1, 0, 4, 32767,  1);
    send(-32768, 0, 0, 0, -32768, 1);
    send(32767,  0, 0, 0, 32767,  1);
    send(-32768, 0, 0, 0, -32768, 1);
    send(32767,  0, 1, 0, 524280, 0);
    send(-32768, 1, 0, 4, -32768, 1);
    send(32767,  0, 0, 0, 32767,  1);
    send(-32768, 0, 0, 0, -32768, 1);
    send(32767,  0, 0, 0, 32767,  1);
    send(-32768, 0, 1, 0, -524280, 0);
    idle(6);

    // order 7 clamps to 4; mid-block restart with order 1
    send(1, 1, 0, 7, 1, 1);
    send(2, 0, 0, 0, 2, 1);
    send(3, 0, 0, 0, 3, 1);
    send(4, 0, 0, 0, 4, 1);
    send(6, 0, 0, 0, 1, 0);
    send(5, 1, 0, 1, 5, 1);
    send(8, 0, 1, 0, 3, 0);
    // 1-sample block, block shorter than order, order 0
    send(9,  1, 1, 3, 9, 1);
    send(5,  1, 0, 4, 5, 1);
    send(6,  0, 1, 0, 6, 1);
    send(-3, 1, 0, 0, -3, 0);
    send(4,  0, 1, 0, 4, 0);
    idle(6);

    // stall with outputs in flight; ignored junk while disabled
    send(10, 1, 0, 1, 10, 1);
    send(13, 0, 0, 0, 3, 0);
    send(9,  0, 0, 0, -4, 0);
    stall(5);
    send(20, 0, 1, 0, 11, 0);
    idle(6);

    // reset mid-block
    send(1, 1, 0, 2, 1, 1);
    send(2, 0, 0, 0, 2, 1);
    send(3, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst         = 1'b1;
    bus.iValid  = 1'b0;
    bus.iStart  = 1'b0;
    bus.iLast   = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_mid_valid", int'(bus.oValid), 0);
    exp_q.delete();
`ifdef FIXED_LPC_ABSSUM_EN
    macc = 0;
`endif
    @(negedge clk);
    rst = 1'b0;
    // order defaults to 0 before any start; iOrder ignored without start
    send(7, 0, 0, 4, 7, 0);
    send(9, 0, 1, 4, 9, 0);
    idle(6);

`ifdef FIXED_LPC_ABSSUM_EN
    send(0,  1, 0, 1, 0, 1);
    send(3,  0, 0, 0, 3, 0);
    send(-1, 0, 0, 0, -4, 0);
    send(4,  0, 1, 0, 5, 0);
    idle(8);
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_outputs", exp_q.size(), 0);
`ifdef FIXED_LPC_ABSSUM_EN
    for (int i = 0; i < 50 && sum_q.size() != 0; i++) @(negedge clk);
    chk("drain_sums", sum_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
